// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: write data, register select,
// qualified write strobe and registered read data.
interface irq_ctrl_if;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic [2:0] addr;
    logic       we;

    modport master (input dbr, output dbw, output addr, output we);
    modport slave  (output dbr, input dbw, input addr, input we);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: up to 8 sources with per-source mask, edge/level
// mode, polarity, pending latches (W1C ack, W1S software set), a priority vector and a
// registered IRQ output.
module irq_ctrl #(
    parameter int unsigned NSRC = 8,
    parameter bit          SYNC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    // One bit per implemented source; applied to every register write and source sample.
    localparam logic [7:0] SrcMask = 8'((16'd1 << NSRC) - 16'd1);

    localparam logic [2:0] AddrPending  = 3'd0;
    localparam logic [2:0] AddrEnable   = 3'd1;
    localparam logic [2:0] AddrAck      = 3'd2;
    localparam logic [2:0] AddrMode     = 3'd3;
    localparam logic [2:0] AddrPolarity = 3'd4;
    localparam logic [2:0] AddrVector   = 3'd5;
    localparam logic [2:0] AddrCtrl     = 3'd6;
    localparam logic [2:0] AddrSwset    = 3'd7;

    logic [NSRC-1:0] s;
    logic [7:0]      s_ext;
    logic [7:0]      prev_q;
    logic [7:0]      pending_q, pending_d;
    logic [7:0]      enable_q, enable_d;
    logic [7:0]      mode_q, mode_d;
    logic [7:0]      pol_q, pol_d;
    logic            gie_q, gie_d;
    logic [7:0]      dbr_q;
    logic            irq_q;
    logic [7:0]      active;
    logic [7:0]      edge_det;
    logic [7:0]      set_bits;
    logic [7:0]      clr_bits;
    logic [7:0]      pend_en;
    logic [7:0]      vector;
    logic [7:0]      rd_data;

    if (SYNC) begin : g_sync
        logic [NSRC-1:0] meta_q;
        logic [NSRC-1:0] sync_q;

        // Two-flop synchronizer per source line.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_q <= '0;
                sync_q <= '0;
            end else begin
                meta_q <= src;
                sync_q <= meta_q;
            end
        end

        assign s = sync_q;
    end else begin : g_nosync
        assign s = src;
    end

    // Zero-extend the source vector to the 8-bit register width.
    always_comb begin
        s_ext = '0;
        s_ext[NSRC-1:0] = s;
    end

    // Source conditioning, pending set/clear and register write decode.
    always_comb begin
        // Current polarity applied to both samples so a polarity write alone makes no edge.
        active   = (s_ext ^ pol_q) & SrcMask;
        edge_det = active & ~(prev_q ^ pol_q);

        set_bits = (mode_q & edge_det) | (~mode_q & active);
        clr_bits = '0;
        if (bus.we && bus.addr == AddrSwset) begin
            set_bits = set_bits | bus.dbw;
        end
        if (bus.we && bus.addr == AddrAck) begin
            clr_bits = bus.dbw;
        end
        set_bits = set_bits & SrcMask;

        // Set wins over a simultaneous clear.
        pending_d = (pending_q & ~clr_bits) | set_bits;

        enable_d = enable_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        gie_d    = gie_q;
        if (bus.we) begin
            unique case (bus.addr)
                AddrEnable:   enable_d = bus.dbw & SrcMask;
                AddrMode:     mode_d   = bus.dbw & SrcMask;
                AddrPolarity: pol_d    = bus.dbw & SrcMask;
                AddrCtrl:     gie_d    = bus.dbw[0];
                default:      ;
            endcase
        end
    end

    // Priority vector: lowest enabled pending bit wins, 0x80 when none.
    always_comb begin
        pend_en = pending_q & enable_q;
        vector  = 8'h80;
        for (int i = 7; i >= 0; i--) begin
            if (pend_en[i]) begin
                vector = {4'b0000, 3'(i), 1'b0};
            end
        end
    end

    // Read mux on pre-update state; registered into dbr below.
    always_comb begin
        rd_data = '0;
        unique case (bus.addr)
            AddrPending:  rd_data = pending_q;
            AddrEnable:   rd_data = enable_q;
            AddrAck:      rd_data = '0;
            AddrMode:     rd_data = mode_q;
            AddrPolarity: rd_data = pol_q;
            AddrVector:   rd_data = vector;
            AddrCtrl:     rd_data = {7'b0, gie_q};
            AddrSwset:    rd_data = '0;
            default:      rd_data = '0;
        endcase
    end

    // State registers, registered read data and registered IRQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= SrcMask;
            pol_q     <= '0;
            gie_q     <= 1'b0;
            dbr_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q    <= s_ext;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            gie_q     <= gie_d;
            dbr_q     <= rd_data;
            irq_q     <= gie_q & (|pend_en);
        end
    end

    assign bus.dbr = dbr_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes expected read data / IRQ levels into
// queues, a negedge monitor pops and compares.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       irq;

    irq_ctrl_if bif ();

    irq_ctrl #(
        .NSRC (8),
        .SYNC (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif),
        .src (src),
        .irq (irq)
    );

    typedef struct {
        logic [7:0] exp;
        bit         is_dbr;
        string      name;
    } chk_t;

    chk_t rd_q[$];
    chk_t imm_q[$];
    logic rd_req;
    logic rd_vld;
    int   n_cmp;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A read issued in one cycle returns its data after the following posedge.
    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: compares registered read data and immediate irq/dbr expectations.
    always @(negedge clk) begin
        chk_t c;
        if (rd_vld === 1'b1) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_underflow: read data %02h with no expectation", bif.dbr);
            end else begin
                c = rd_q.pop_front();
                if (bif.dbr !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: dbr=%02h expected %02h", c.name, bif.dbr, c.exp);
                end
            end
        end
        while (imm_q.size() > 0) begin
            c = imm_q.pop_front();
            n_cmp++;
            if (c.is_dbr) begin
                if (bif.dbr !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: dbr=%02h expected %02h", c.name, bif.dbr, c.exp);
                end
            end else if (irq !== c.exp[0]) begin
                n_err++;
                $display("FAIL %s: irq=%b expected %b", c.name, irq, c.exp[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        chk_t c;
        c.exp = exp;
        c.is_dbr = 1'b0;
        c.name = name;
        rd_q.push_back(c);
        bif.addr = a;
        bif.we = 1'b0;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bif.addr = a;
        bif.dbw = d;
        bif.we = 1'b1;
        tick();
        bif.we = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string name);
        chk_t c;
        c.exp = {7'b0, e};
        c.is_dbr = 1'b0;
        c.name = name;
        imm_q.push_back(c);
    endtask

    task automatic chk_dbr_now(input logic [7:0] e, input string name);
        chk_t c;
        c.exp = e;
        c.is_dbr = 1'b1;
        c.name = name;
        imm_q.push_back(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rd_req = 1'b0;
        rst = 1'b1;
        src = 8'h00;
        bif.addr = 3'd0;
        bif.dbw = 8'h00;
        bif.we = 1'b0;
        ticks(3);
        rst = 1'b0;
        tick();

        // Reset values of all registers.
        rd(3'd0, 8'h00, "rst_pending");
        rd(3'd1, 8'h00, "rst_enable");
        rd(3'd2, 8'h00, "rst_ack");
        rd(3'd3, 8'hFF, "rst_mode");
        rd(3'd4, 8'h00, "rst_polarity");
        rd(3'd5, 8'h80, "rst_vector");
        rd(3'd6, 8'h00, "rst_ctrl");
        rd(3'd7, 8'h00, "rst_swset");
        chk_irq(1'b0, "rst_irq");

        // Edge source 3: one-cycle pulse, pending after 2 edges, irq after 3.
        wr(3'd1, 8'h08);
        wr(3'd6, 8'h01);
        rd(3'd6, 8'h01, "ctrl_gie");
        src = 8'h08;
        tick();                       // posedge 0
        src = 8'h00;
        ticks(2);                     // posedges 1, 2
        chk_irq(1'b0, "edge_irq_not_yet");
        rd(3'd0, 8'h08, "edge_pending");
        chk_irq(1'b1, "edge_irq");
        rd(3'd5, 8'h06, "edge_vector");
        wr(3'd2, 8'h08);
        chk_irq(1'b1, "ack_irq_lag");
        tick();
        chk_irq(1'b0, "ack_irq_low");
        rd(3'd0, 8'h00, "ack_pending");

        // Level source 5: ACK while held re-pends; drop then ACK clears.
        wr(3'd3, 8'hDF);
        wr(3'd1, 8'h20);
        src = 8'h20;
        ticks(4);
        chk_irq(1'b1, "level_irq");
        rd(3'd0, 8'h20, "level_pending");
        wr(3'd2, 8'h20);
        rd(3'd0, 8'h20, "level_repend");
        chk_irq(1'b1, "level_irq_held");
        src = 8'h00;
        ticks(3);
        wr(3'd2, 8'h20);
        tick();
        chk_irq(1'b0, "level_irq_drop");
        rd(3'd0, 8'h00, "level_cleared");
        wr(3'd3, 8'hFF);

        // Priority: sources 1 and 6 pending.
        src = 8'h42;
        tick();
        src = 8'h00;
        ticks(3);
        wr(3'd1, 8'h42);
        rd(3'd5, 8'h02, "vec_bit1");
        chk_irq(1'b1, "vec_irq");
        wr(3'd1, 8'h40);
        rd(3'd5, 8'h0C, "vec_bit6");
        wr(3'd6, 8'h00);
        tick();
        chk_irq(1'b0, "gie_off_irq");
        rd(3'd5, 8'h0C, "gie_off_vector");
        wr(3'd2, 8'hFF);
        wr(3'd1, 8'h00);
        wr(3'd6, 8'h01);
        rd(3'd0, 8'h00, "prio_cleared");

        // Polarity: write with steady input makes no edge; active-low pends on fall only.
        wr(3'd4, 8'h01);
        ticks(3);
        rd(3'd0, 8'h00, "pol_write_no_edge");
        rd(3'd4, 8'h01, "pol_readback");
        src = 8'h01;
        ticks(4);
        rd(3'd0, 8'h00, "pol_rise_ignored");
        src = 8'h00;
        ticks(3);
        rd(3'd0, 8'h01, "pol_fall_pends");
        wr(3'd2, 8'h01);
        wr(3'd4, 8'h00);
        ticks(2);
        rd(3'd0, 8'h00, "pol_restored");

        // Edge set on bit 2 in the same cycle as its ACK: set wins.
        src = 8'h04;
        tick();                       // posedge 0
        src = 8'h00;
        tick();                       // posedge 1: edge visible until posedge 2
        wr(3'd2, 8'h04);
        rd(3'd0, 8'h04, "set_beats_clr");
        wr(3'd7, 8'h80);
        rd(3'd0, 8'h84, "swset");
        wr(3'd1, 8'h80);
        tick();
        chk_irq(1'b1, "swset_irq");
        rd(3'd5, 8'h0E, "swset_vector");
        chk_dbr_now(8'h0E, "pre_rst_dbr");

        // Asynchronous reset with irq high: outputs drop without a posedge.
        tick();
        rst = 1'b1;
        #2;
        chk_irq(1'b0, "async_rst_irq");
        chk_dbr_now(8'h00, "async_rst_dbr");
        @(negedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();
        rd(3'd0, 8'h00, "post_rst_pending");
        rd(3'd1, 8'h00, "post_rst_enable");
        ticks(2);

        while (rd_q.size() > 0) begin
            chk_t c;
            c = rd_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: no read data observed, expected %02h", c.name, c.exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
